// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one 64-bit memory port between fetch (I) and load/store (D); optional macro ARB_ROUND_ROBIN_EN
module mem_port_arbiter #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_valid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic [7:0]  d_wmask,
    output logic        d_valid,
    output logic [63:0] d_rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata
);
    // Counter holds the number of completed BUSY cycles; abort fires in the cycle where it reads TIMEOUT_CYC-1.
    localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           sel_hi_q, sel_hi_d;
    logic           i_valid_q, i_valid_d;
    logic [31:0]    i_rdata_q, i_rdata_d;
    logic           d_valid_q, d_valid_d;
    logic [63:0]    d_rdata_q, d_rdata_d;
    logic           err_q, err_d;
    logic           mem_req_q, mem_req_d;
    logic           mem_we_q, mem_we_d;
    logic [31:0]    mem_addr_q, mem_addr_d;
    logic [63:0]    mem_wdata_q, mem_wdata_d;
    logic [7:0]     mem_wmask_q, mem_wmask_d;
    logic           grant_d_w;

`ifdef ARB_ROUND_ROBIN_EN
    logic           last_d_q, last_d_d;  // 1 = D was granted last, 0 = I (reset)
    assign grant_d_w = d_req && (!i_req || !last_d_q);
`else
    assign grant_d_w = d_req;
`endif

    // Next-state and output computation for the access sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_hi_d    = sel_hi_q;
        i_valid_d   = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_valid_d   = 1'b0;
        d_rdata_d   = d_rdata_q;
        err_d       = err_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d_d    = last_d_q;
`endif
        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (grant_d_w) begin
                    state_d     = BUSY_D;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_wmask_d = d_we ? d_wmask : 8'h00;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_d    = 1'b1;
`endif
                end else if (i_req) begin
                    state_d     = BUSY_I;
                    cnt_d       = '0;
                    sel_hi_d    = i_addr[2];
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = {i_addr[31:3], 3'b000};
                    mem_wdata_d = 64'h0;
                    mem_wmask_d = 8'h00;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_d    = 1'b0;
`endif
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack) begin
                    // Ack beats a coinciding timeout
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    err_d     = 1'b0;
                    if (state_q == BUSY_I) begin
                        i_valid_d = 1'b1;
                        i_rdata_d = sel_hi_q ? mem_rdata[63:32] : mem_rdata[31:0];
                    end else begin
                        d_valid_d = 1'b1;
                        d_rdata_d = mem_we_q ? 64'h0 : mem_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (state_q == BUSY_I) begin
                        i_valid_d = 1'b1;
                        i_rdata_d = 32'h0;
                    end else begin
                        d_valid_d = 1'b1;
                        d_rdata_d = 64'h0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops mem_req immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_hi_q    <= 1'b0;
            i_valid_q   <= 1'b0;
            i_rdata_q   <= 32'h0;
            d_valid_q   <= 1'b0;
            d_rdata_q   <= 64'h0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 64'h0;
            mem_wmask_q <= 8'h00;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_hi_q    <= sel_hi_d;
            i_valid_q   <= i_valid_d;
            i_rdata_q   <= i_rdata_d;
            d_valid_q   <= d_valid_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q    <= last_d_d;
`endif
        end
    end

    assign i_valid   = i_valid_q;
    assign i_rdata   = i_rdata_q;
    assign d_valid   = d_valid_q;
    assign d_rdata   = d_rdata_q;
    assign err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;

endmodule
